// File: rtl/uart_rx.sv
// 8E1 serial receiver: start, 8 data bits LSB first, even parity, stop.
// Emits a one-cycle dval_out per clean frame; parity/framing errors are silently dropped.
module uart_rx #(
    parameter int CLK_FREQ = 200_000_000,
    parameter int BAUD     = 57600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_in,
    output logic [7:0] dout,
    output logic       dval_out,
    output logic       idle_out
);

    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } state_t;

    state_t        state_r;
    logic [1:0]    sync_r;
    logic          rxs_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic          perr_r;

    function automatic logic odd_ones(input logic [7:0] d);
        return ^d;
    endfunction

    assign rxs_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd_in};
        end
    end

    // Frame FSM with bit-time counter; all outputs registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            perr_r   <= 1'b0;
            dout     <= 8'h00;
            dval_out <= 1'b0;
            idle_out <= 1'b1;
        end else begin
            dval_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (!rxs_s) begin
                        state_r  <= START;
                        idle_out <= 1'b0;
                    end else begin
                        idle_out <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        idx_r <= 3'd0;
                        if (rxs_s) begin
                            state_r  <= IDLE;
                            idle_out <= 1'b1;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r          <= '0;
                        shift_r[idx_r] <= rxs_s;
                        if (idx_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                PARITY: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        perr_r  <= rxs_s ^ odd_ones(shift_r);
                        state_r <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r <= '0;
                        if (rxs_s) begin
                            // Back in IDLE mid-stop-bit so an immediately following start is caught
                            state_r  <= IDLE;
                            idle_out <= 1'b1;
                            if (!perr_r) begin
                                dout     <= shift_r;
                                dval_out <= 1'b1;
                            end else begin
                                dout <= dout;
                            end
                        end else begin
                            state_r <= RECOVER;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RECOVER: begin
                    cnt_r <= '0;
                    if (rxs_s) begin
                        state_r  <= IDLE;
                        idle_out <= 1'b1;
                    end else begin
                        idle_out <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    idle_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 clocks per bit: framing, back-to-back, baud skew,
// parity/stop errors, mid-frame reset and line noise checked against the recorded line.
module tb_uart_rx;

    localparam int CLK_FREQ = 2_880_000;
    localparam int BAUD     = 57600;
    localparam int B        = 50;
    localparam int H        = 25;
    localparam int LAT      = 3 + H + 10 * B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] dout;
    logic       dval_out;
    logic       idle_out;

    int vectors = 0;
    int miscompares = 0;

    int         cyc = 0;
    logic       hist [0:65535];
    logic [7:0] rx_q [$];
    int         rx_c [$];
    int         glitch = 0;
    logic [7:0] prev_dout = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd_in   (rxd),
        .dout     (dout),
        .dval_out (dval_out),
        .idle_out (idle_out)
    );

    always #5 clk = ~clk;

    // Cycle counter and line history (hist[n] = level driven at the negedge where cyc==n)
    always @(posedge clk) begin
        hist[cyc] <= rxd;
        cyc <= cyc + 1;
    end

    // Pulse recorder and watch for dout moving outside a strobe
    always @(negedge clk) begin
        if (rst) begin
            prev_dout <= dout;
        end else begin
            if (dval_out) begin
                rx_q.push_back(dout);
                rx_c.push_back(cyc);
            end else if (dout !== prev_dout) begin
                glitch <= glitch + 1;
            end
            prev_dout <= dout;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic p, input int bc, output int edge_c);
        rxd = 1'b0;
        edge_c = cyc;
        idle(bc);
        for (int k = 0; k < 8; k++) begin
            rxd = d[k];
            idle(bc);
        end
        rxd = p;
        idle(bc);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int bc, output int edge_c);
        send_bits(d, p, bc, edge_c);
        rxd = 1'b1;
        idle(bc);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(500);
        vectors++;
        if (rx_q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_dval: got %0d pulses want 0", rx_q.size());
        end
        vectors++;
        if (idle_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 1", idle_out);
        end
        vectors++;
        if (dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_dout: got %h want 00", dout);
        end
    endtask

    task automatic test_back_to_back;
        int e [2];
        logic [7:0] exp_d [2];
        exp_d[0] = 8'h68;
        exp_d[1] = 8'h69;
        rx_q.delete();
        rx_c.delete();
        send_frame(8'h68, 1'b1, B, e[0]);
        send_frame(8'h69, 1'b0, B, e[1]);
        idle(2 * B);
        vectors++;
        if (rx_q.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (rx_q[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got %h want %h", i, rx_q[i], exp_d[i]);
                end
                vectors++;
                if (rx_c[i] < e[i] + LAT - 4 || rx_c[i] > e[i] + LAT + 4) begin
                    miscompares++;
                    $display("FAIL b2b_lat%0d: got %0d want %0d+-4", i, rx_c[i] - e[i], LAT);
                end
            end
        end
    endtask

    task automatic test_ascii_192;
        int e [3];
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h31;
        exp_d[1] = 8'h39;
        exp_d[2] = 8'h32;
        rx_q.delete();
        rx_c.delete();
        send_frame(8'h31, 1'b1, B, e[0]);
        send_frame(8'h39, 1'b0, B, e[1]);
        send_frame(8'h32, 1'b1, B, e[2]);
        idle(2 * B);
        vectors++;
        if (rx_q.size() !== 3) begin
            miscompares++;
            $display("FAIL ascii_count: got %0d want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (rx_q[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL ascii_data%0d: got %h want %h", i, rx_q[i], exp_d[i]);
                end
                vectors++;
                if (rx_c[i] < e[i] + LAT - 4 || rx_c[i] > e[i] + LAT + 4) begin
                    miscompares++;
                    $display("FAIL ascii_lat%0d: got %0d want %0d+-4", i, rx_c[i] - e[i], LAT);
                end
            end
        end
    endtask

    task automatic test_baud_mismatch;
        int e0, e1;
        rx_q.delete();
        rx_c.delete();
        send_frame(8'hA5, 1'b0, B - 1, e0);
        send_frame(8'h5A, 1'b0, B + 1, e1);
        send_frame(8'h32, 1'b1, B, e0);
        idle(2 * B);
        vectors++;
        if (rx_q.size() !== 3) begin
            miscompares++;
            $display("FAIL skew_count: got %0d want 3", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL skew_slow: got %h want a5", rx_q[0]);
            end
            vectors++;
            if (rx_q[1] !== 8'h5A) begin
                miscompares++;
                $display("FAIL skew_fast: got %h want 5a", rx_q[1]);
            end
        end
    endtask

    task automatic test_parity_error;
        int e;
        rx_q.delete();
        rx_c.delete();
        send_frame(8'h0F, 1'b1, B, e);
        idle(5);
        vectors++;
        if (rx_q.size() !== 0) begin
            miscompares++;
            $display("FAIL perr_dval: got %0d pulses want 0", rx_q.size());
        end
        vectors++;
        if (dout !== 8'h32) begin
            miscompares++;
            $display("FAIL perr_dout: got %h want 32", dout);
        end
        vectors++;
        if (idle_out !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_idle: got %b want 1", idle_out);
        end
    endtask

    task automatic test_break;
        int e;
        int viol;
        logic [7:0] bytes [2];
        int lows [2];
        bytes[0] = 8'h33;
        bytes[1] = 8'h3C;
        lows[0] = 2;
        lows[1] = 3;
        rx_q.delete();
        rx_c.delete();
        for (int i = 0; i < 2; i++) begin
            send_bits(bytes[i], 1'b0, B, e);
            rxd = 1'b0;
            viol = 0;
            repeat (lows[i] * B) begin
                @(negedge clk);
                if (idle_out !== 1'b0) viol++;
            end
            vectors++;
            if (viol !== 0) begin
                miscompares++;
                $display("FAIL break_idle%0d: got %0d cycles idle high want 0", i, viol);
            end
            rxd = 1'b1;
            idle(B);
            vectors++;
            if (idle_out !== 1'b1) begin
                miscompares++;
                $display("FAIL break_rearm%0d: got %b want 1", i, idle_out);
            end
        end
        send_frame(8'hA5, 1'b0, B, e);
        idle(B);
        vectors++;
        if (rx_q.size() !== 1) begin
            miscompares++;
            $display("FAIL break_count: got %0d want 1", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL break_after: got %h want a5", rx_q[0]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        rx_q.delete();
        rx_c.delete();
        rxd = 1'b0;
        idle(B);
        rxd = 1'b1;
        idle(3 * B);
        rst = 1'b1;
        idle(3);
        vectors++;
        if (dout !== 8'h00 || idle_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_during: got dout=%h idle=%b want 00/1", dout, idle_out);
        end
        rst = 1'b0;
        idle(12 * B);
        vectors++;
        if (rx_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rstmid_dval: got %0d pulses want 0", rx_q.size());
        end
        vectors++;
        if (dout !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_dout: got %h want 00", dout);
        end
    endtask

    task automatic test_noise;
        int e, c, base;
        logic [7:0] rb;
        logic ok;
        rx_q.delete();
        rx_c.delete();
        for (int i = 0; i < 200; i++) begin
            rxd = ~rxd;
            idle($urandom_range(0, 29));
        end
        rxd = 1'b1;
        idle(15 * B);
        for (int i = 0; i < rx_q.size(); i++) begin
            c = rx_c[i];
            base = c - 3;
            ok = 1'b0;
            if (base - 10 * B >= 0) begin
                for (int k = 0; k < 8; k++) rb[k] = hist[base - (9 - k) * B];
                ok = (hist[base] == 1'b1) && (hist[base - 10 * B] == 1'b0) &&
                     (rb == rx_q[i]) && ((^rb ^ hist[base - B]) == 1'b0);
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL noise_frame%0d: got %h at cyc %0d want a line-valid frame", i, rx_q[i], c);
            end
        end
        vectors++;
        if (idle_out !== 1'b1) begin
            miscompares++;
            $display("FAIL noise_hang: got idle=%b want 1", idle_out);
        end
        rx_q.delete();
        rx_c.delete();
        send_frame(8'h55, 1'b0, B, e);
        idle(B);
        vectors++;
        if (rx_q.size() !== 1) begin
            miscompares++;
            $display("FAIL noise_count: got %0d want 1", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== 8'h55) begin
                miscompares++;
                $display("FAIL noise_55: got %h want 55", rx_q[0]);
            end
            vectors++;
            if (rx_c[0] < e + LAT - 4 || rx_c[0] > e + LAT + 4) begin
                miscompares++;
                $display("FAIL noise_lat: got %0d want %0d+-4", rx_c[0] - e, LAT);
            end
        end
    endtask

    task automatic test_dout_stable;
        vectors++;
        if (glitch !== 0) begin
            miscompares++;
            $display("FAIL dout_stable: got %0d changes outside strobe want 0", glitch);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_ascii_192;
        test_baud_mismatch;
        test_parity_error;
        test_break;
        test_noise;
        test_dout_stable;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
